serial_mag_comparator: RTL and testbench

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

---
 rtl/serial_mag_comparator_if.sv | 24 ++
 rtl/serial_mag_comparator.sv | 117 +++++++++++
 tb/tb_serial_mag_comparator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_mag_comparator_if.sv
// Operand/result bundle for serial_mag_comparator.
// The master side drives the start request and operands. The slave side returns status and the registered result.
interface serial_mag_comparator_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic         AgtB;
  logic         AeqB;
  logic         AltB;

  modport master (
    output start, A, B,
    input  busy, done, AgtB, AeqB, AltB
  );

  modport slave (
    input  start, A, B,
    output busy, done, AgtB, AeqB, AltB
  );
endinterface

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator: one bit pair per clock, registered one-hot result.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN ends a comparison on the first differing bit.
module serial_mag_comparator #(
  parameter int N = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_mag_comparator_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // pq cell state of the iterative comparator network; 00 never occurs
  localparam logic [1:0] PQ_EQ = 2'b01;
  localparam logic [1:0] PQ_GT = 2'b11;
  localparam logic [1:0] PQ_LT = 2'b10;

  state_t         state, state_nxt;
  logic [1:0]     pq, pq_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [N-1:0]   a_sh, a_nxt;
  logic [N-1:0]   b_sh, b_nxt;
  logic           agt, aeq, alt;
  logic           accept;
  logic           bit_diff;
  logic           last_bit;
  logic           finish;
  logic           res_load;

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_nxt = state;
    pq_nxt    = pq;
    cnt_nxt   = cnt;
    a_nxt     = a_sh;
    b_nxt     = b_sh;
    res_load  = 1'b0;
    finish    = 1'b0;

    accept   = bus.start && (state != COMPARE);
    bit_diff = a_sh[N-1] ^ b_sh[N-1];
    last_bit = (cnt == CW'(1));

    case (state)
      IDLE, DONE: begin
        if (accept) begin
          a_nxt     = bus.A;
          b_nxt     = bus.B;
          pq_nxt    = PQ_EQ;
          cnt_nxt   = CW'(N);
          state_nxt = COMPARE;
        end else begin
          state_nxt = IDLE;
        end
      end

      COMPARE: begin
        // The first differing bit settles the result; later bits cannot change it.
        if (pq == PQ_EQ && bit_diff)
          pq_nxt = a_sh[N-1] ? PQ_GT : PQ_LT;
        a_nxt   = {a_sh[N-2:0], 1'b0};
        b_nxt   = {b_sh[N-2:0], 1'b0};
        cnt_nxt = cnt - CW'(1);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        finish = last_bit || (pq == PQ_EQ && bit_diff);
`else
        finish = last_bit;
`endif
        if (finish) begin
          state_nxt = DONE;
          res_load  = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pq    <= PQ_EQ;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      agt   <= 1'b0;
      aeq   <= 1'b1;
      alt   <= 1'b0;
    end else begin
      // NOTE: all state updates use non-blocking assignments, so every register samples the values from before this edge.
      state <= state_nxt;
      pq    <= pq_nxt;
      cnt   <= cnt_nxt;
      a_sh  <= a_nxt;
      b_sh  <= b_nxt;
      if (res_load) begin
        agt <= (pq_nxt == PQ_GT);
        aeq <= (pq_nxt == PQ_EQ);
        alt <= (pq_nxt == PQ_LT);
      end
    end
  end

  // DONE never lasts longer than one cycle, so the state alone forms the pulse.
  assign bus.busy = (state == COMPARE);
  assign bus.done = (state == DONE);
  assign bus.AgtB = agt;
  assign bus.AeqB = aeq;
  assign bus.AltB = alt;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator (N = 8).
// Directed cases plus random traffic, all checked against an arithmetic reference model.
module tb_serial_mag_comparator;

  localparam int N = 8;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_mag_comparator_if #(.N(N)) ifc ();

  serial_mag_comparator #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // The result is {gt, eq, lt}, computed from plain magnitude comparison.
  function automatic logic [2:0] exp_result(input logic [N-1:0] a, input logic [N-1:0] b);
    if (a > b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  // This is the number of bit-processing edges. With early exit, the count stops at the first difference (MSB = 1).
  function automatic int exp_bits(input logic [N-1:0] a, input logic [N-1:0] b);
    for (int i = N - 1; i >= 0; i--)
      if (a[i] != b[i]) return EARLY ? (N - i) : N;
    return N;
  endfunction

  // Reference model: a countdown of the remaining bit edges and a pending result.
  logic       m_busy, m_done;
  int         m_rem;
  logic [2:0] m_res, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_rem  <= 0;
      m_res  <= 3'b010;
      m_pend <= 3'b010;
    end else if (!m_busy && ifc.start) begin
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_rem  <= exp_bits(ifc.A, ifc.B);
      m_pend <= exp_result(ifc.A, ifc.B);
    end else if (m_busy) begin
      if (m_rem == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_pend;
      end else begin
        m_rem <= m_rem - 1;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("model_vs_dut", {27'd0, ifc.busy, ifc.done, ifc.AgtB, ifc.AeqB, ifc.AltB},
          {27'd0, m_busy, m_done, m_res});
  end

  // This task is called at a negedge. It pulses start, then counts edges until done is seen.
  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int exp_edges, input logic [2:0] exp_res);
    int edges;
    ifc.start = 1'b1;
    ifc.A = a;
    ifc.B = b;
    @(negedge clk);
    ifc.start = 1'b0;
    edges = 1;
    while (!ifc.done && edges < 50) begin
      @(negedge clk);
      edges++;
    end
    check({name, "_latency"}, edges, exp_edges);
    check({name, "_result"}, {29'd0, ifc.AgtB, ifc.AeqB, ifc.AltB}, {29'd0, exp_res});
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((ifc.busy || ifc.done) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("wait_idle", {31'd0, ifc.busy || ifc.done}, 32'd0);
  endtask

  initial begin
    int last_done;
    int gaps;
    logic [N-1:0] ra, rb;

    ifc.start = 1'b0;
    ifc.A = '0;
    ifc.B = '0;

    repeat (2) @(negedge clk);
    check("reset_outputs", {27'd0, ifc.busy, ifc.done, ifc.AgtB, ifc.AeqB, ifc.AltB}, 32'b00010);

    // Release reset and request a start on the very first edge.
    rst_n = 1'b1;
    run_op("eq_a5", 8'hA5, 8'hA5, 9, 3'b010);
    run_op("gt_80_7f", 8'h80, 8'h7F, EARLY ? 2 : 9, 3'b100);
    run_op("lt_12_13", 8'h12, 8'h13, 9, 3'b001);
    wait_idle();

    // A second start during COMPARE is ignored.
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.A = 8'h00;
    ifc.B = 8'hFF;
    @(negedge clk);
    check("busy_after_start", {31'd0, ifc.busy}, 32'd1);
    ifc.A = 8'hFF;
    ifc.B = 8'h00;
    @(negedge clk);
    ifc.start = 1'b0;
    gaps = 0;
    while (!ifc.done && gaps < 50) begin
      @(negedge clk);
      gaps++;
    end
    check("ignored_start_result", {29'd0, ifc.AgtB, ifc.AeqB, ifc.AltB}, 32'b001);
    @(negedge clk);
    check("ignored_start_no_restart", {31'd0, ifc.busy}, 32'd0);

    // Reset arrives at bit 4 of a comparison.
    ifc.start = 1'b1;
    ifc.A = 8'h55;
    ifc.B = 8'h55;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {27'd0, ifc.busy, ifc.done, ifc.AgtB, ifc.AeqB, ifc.AltB}, 32'b00010);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_reset_quiet", {27'd0, ifc.busy, ifc.done, ifc.AgtB, ifc.AeqB, ifc.AltB}, 32'b00010);
    end
    run_op("gt_01_00", 8'h01, 8'h00, 9, 3'b100);
    wait_idle();

    // With start held high, comparisons run back to back. The LSB differs, so the period is 9 in both builds.
    ifc.start = 1'b1;
    ifc.A = 8'h3C;
    ifc.B = 8'h3D;
    last_done = -1;
    gaps = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (ifc.done) begin
        if (last_done >= 0) begin
          check("held_start_period", cyc - last_done, 9);
          gaps++;
        end
        check("held_start_result", {29'd0, ifc.AgtB, ifc.AeqB, ifc.AltB}, 32'b001);
        last_done = cyc;
      end
    end
    check("held_start_pulses", (gaps >= 5) ? 32'd1 : 32'd0, 32'd1);
    ifc.start = 1'b0;
    wait_idle();

    // Random traffic with random start pulses. The model checks every cycle.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ N'(1 << $urandom_range(0, N - 1));
        default: ;
      endcase
      ifc.A = ra;
      ifc.B = rb;
      ifc.start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    ifc.start = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
